// File: rtl/csr_access_unit.sv
// Zicsr execution unit: reads a CSR through the external read mux, computes the
// CSRRW/CSRRS/CSRRC (and immediate) result, strobes the write and returns the old value.
module csr_access_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_funct3,
    input  logic [11:0]     req_addr,
    input  logic [4:0]      req_rs1_field,
    input  logic [XLEN-1:0] req_rs1_data,
    output logic [11:0]     mux_addr,
    input  logic [XLEN-1:0] mux_data,
    input  logic            mux_fail,
    output logic            csr_we,
    output logic [11:0]     csr_waddr,
    output logic [XLEN-1:0] csr_wdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_illegal
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t            state_q, state_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [11:0]       addr_q, addr_d;
    logic [4:0]        rs1_field_q, rs1_field_d;
    logic [XLEN-1:0]   rs1_data_q, rs1_data_d;
    logic [11:0]       mux_addr_q, mux_addr_d;
    logic [XLEN-1:0]   old_q, old_d;
    logic              illegal_q, illegal_d;
    logic              csr_we_q, csr_we_d;
    logic [11:0]       csr_waddr_q, csr_waddr_d;
    logic [XLEN-1:0]   csr_wdata_q, csr_wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [XLEN-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic              rsp_illegal_q, rsp_illegal_d;

    logic [XLEN-1:0]   src;
    logic              wr_intent;
    logic              illegal_rd;
    logic [XLEN-1:0]   new_val;

    // Set/clear forms with a zero source (x0 or uimm 0) are pure reads.
    always_comb begin
        src        = funct3_q[2] ? {{(XLEN-5){1'b0}}, rs1_field_q} : rs1_data_q;
        wr_intent  = (funct3_q[1:0] == 2'b01) || (funct3_q[1] && (rs1_field_q != 5'd0));
        illegal_rd = mux_fail || (funct3_q[1:0] == 2'b00) ||
                     (wr_intent && (addr_q[11:10] == 2'b11));
        case (funct3_q[1:0])
            2'b01:   new_val = src;
            2'b10:   new_val = mux_data | src;
            2'b11:   new_val = mux_data & ~src;
            default: new_val = mux_data;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        funct3_d      = funct3_q;
        addr_d        = addr_q;
        rs1_field_d   = rs1_field_q;
        rs1_data_d    = rs1_data_q;
        mux_addr_d    = mux_addr_q;
        old_d         = old_q;
        illegal_d     = illegal_q;
        csr_we_d      = 1'b0;
        csr_waddr_d   = csr_waddr_q;
        csr_wdata_d   = csr_wdata_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_illegal_d = rsp_illegal_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    funct3_d    = req_funct3;
                    addr_d      = req_addr;
                    rs1_field_d = req_rs1_field;
                    rs1_data_d  = req_rs1_data;
                    mux_addr_d  = req_addr;
                    state_d     = READ;
                end
            end
            READ: begin
                old_d       = mux_data;
                illegal_d   = illegal_rd;
                csr_we_d    = wr_intent && !illegal_rd;
                csr_waddr_d = addr_q;
                csr_wdata_d = new_val;
                state_d     = WRITE;
            end
            WRITE: begin
                rsp_valid_d   = 1'b1;
                rsp_rdata_d   = illegal_q ? '0 : old_q;
                rsp_illegal_d = illegal_q;
                state_d       = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            funct3_q      <= '0;
            addr_q        <= '0;
            rs1_field_q   <= '0;
            rs1_data_q    <= '0;
            mux_addr_q    <= '0;
            old_q         <= '0;
            illegal_q     <= 1'b0;
            csr_we_q      <= 1'b0;
            csr_waddr_q   <= '0;
            csr_wdata_q   <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_illegal_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            funct3_q      <= funct3_d;
            addr_q        <= addr_d;
            rs1_field_q   <= rs1_field_d;
            rs1_data_q    <= rs1_data_d;
            mux_addr_q    <= mux_addr_d;
            old_q         <= old_d;
            illegal_q     <= illegal_d;
            csr_we_q      <= csr_we_d;
            csr_waddr_q   <= csr_waddr_d;
            csr_wdata_q   <= csr_wdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_illegal_q <= rsp_illegal_d;
        end
    end

    assign req_ready   = (state_q == IDLE);
    assign mux_addr    = mux_addr_q;
    assign csr_we      = csr_we_q;
    assign csr_waddr   = csr_waddr_q;
    assign csr_wdata   = csr_wdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_illegal = rsp_illegal_q;

endmodule

// File: tb/tb_csr_access_unit.sv
// Directed bench for csr_access_unit with a small CSR file behind the read mux.
module tb_csr_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic [11:0] req_addr;
    logic [4:0]  req_rs1_field;
    logic [31:0] req_rs1_data;
    logic [11:0] mux_addr;
    logic [31:0] mux_data;
    logic        mux_fail;
    logic        csr_we;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_illegal;

    int checks = 0;
    int failures = 0;

    logic [31:0] m_mscratch = 32'h0000_0000;
    logic [31:0] m_mstatus  = 32'h0000_1800;
    logic [31:0] m_mip      = 32'h0000_0080;

    always #5 clk = ~clk;

    csr_access_unit #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_rs1_field(req_rs1_field), .req_rs1_data(req_rs1_data),
        .mux_addr(mux_addr), .mux_data(mux_data), .mux_fail(mux_fail),
        .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_illegal(rsp_illegal)
    );

    // CSR read mux model; mvendorid is read-only with a nonzero value
    always_comb begin
        mux_data = 32'h0;
        mux_fail = 1'b0;
        case (mux_addr)
            12'h340: mux_data = m_mscratch;
            12'h300: mux_data = m_mstatus;
            12'h344: mux_data = m_mip;
            12'hF11: mux_data = 32'h0000_0ABC;
            default: mux_fail = 1'b1;
        endcase
    end

    always @(posedge clk) begin
        if (csr_we) begin
            case (csr_waddr)
                12'h340: m_mscratch <= csr_wdata;
                12'h300: m_mstatus  <= csr_wdata;
                12'h344: m_mip      <= csr_wdata;
                default: ;
            endcase
        end
    end

    // Runs one transaction; cycle k = k-th falling edge after the accepting edge.
    task automatic run_txn(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] r1f,
                           input logic [31:0] r1d, output int we_cnt, output int we_cycle,
                           output logic [31:0] wdata, output logic [11:0] waddr,
                           output int rsp_cycle, output logic [31:0] rdata,
                           output logic ill, output logic ok);
        int waitc;
        we_cnt = 0; we_cycle = -1; rsp_cycle = -1;
        wdata = '0; waddr = '0; rdata = '0; ill = 1'b0; ok = 1'b1;
        @(negedge clk);
        waitc = 0;
        while (!req_ready && waitc < 20) begin @(negedge clk); waitc++; end
        if (!req_ready) begin ok = 1'b0; return; end
        req_valid = 1'b1; req_funct3 = f3; req_addr = a; req_rs1_field = r1f; req_rs1_data = r1d;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (csr_we) begin we_cnt++; we_cycle = k; wdata = csr_wdata; waddr = csr_waddr; end
            if (rsp_valid) begin
                rsp_cycle = k; rdata = rsp_rdata; ill = rsp_illegal;
                rsp_ready = 1'b1;
                @(posedge clk);
                @(negedge clk);
                rsp_ready = 1'b0;
                break;
            end
            @(negedge clk);
        end
        if (rsp_cycle < 0) ok = 1'b0;
        $display("txn f3=%0d addr=%h rs1f=%0d rs1d=%h -> we=%0d@%0d wdata=%h rsp@%0d rdata=%h ill=%0b",
                 f3, a, r1f, r1d, we_cnt, we_cycle, wdata, rsp_cycle, rdata, ill);
    endtask

    int          t_we_cnt, t_we_cycle, t_rsp_cycle;
    logic [31:0] t_wdata, t_rdata;
    logic [11:0] t_waddr;
    logic        t_ill, t_ok;

    task automatic test_reset();
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        checks++; if (mux_addr !== 12'h0) begin failures++; $display("FAIL reset_mux_addr got=%h exp=000", mux_addr); end
        checks++; if (csr_we !== 1'b0) begin failures++; $display("FAIL reset_csr_we got=%b exp=0", csr_we); end
        checks++; if (csr_waddr !== 12'h0 || csr_wdata !== 32'h0) begin failures++; $display("FAIL reset_wport got=%h/%h exp=0/0", csr_waddr, csr_wdata); end
        checks++; if (rsp_valid !== 1'b0 || rsp_illegal !== 1'b0) begin failures++; $display("FAIL reset_rsp_flags got=%b/%b exp=0/0", rsp_valid, rsp_illegal); end
        checks++; if (rsp_rdata !== 32'h0) begin failures++; $display("FAIL reset_rsp_rdata got=%h exp=0", rsp_rdata); end
    endtask

    task automatic test_csrrw();
        run_txn(3'b001, 12'h340, 5'd5, 32'hDEAD_BEEF, t_we_cnt, t_we_cycle, t_wdata, t_waddr, t_rsp_cycle, t_rdata, t_ill, t_ok);
        checks++; if (t_ok !== 1'b1) begin failures++; $display("FAIL rw_timeout got=%b exp=1", t_ok); end
        checks++; if (t_we_cnt !== 1 || t_we_cycle !== 2) begin failures++; $display("FAIL rw_we_timing got=%0d@%0d exp=1@2", t_we_cnt, t_we_cycle); end
        checks++; if (t_wdata !== 32'hDEAD_BEEF || t_waddr !== 12'h340) begin failures++; $display("FAIL rw_wdata got=%h@%h exp=deadbeef@340", t_wdata, t_waddr); end
        checks++; if (t_rsp_cycle !== 3) begin failures++; $display("FAIL rw_rsp_latency got=%0d exp=3", t_rsp_cycle); end
        checks++; if (t_rdata !== 32'h0 || t_ill !== 1'b0) begin failures++; $display("FAIL rw_rsp got=%h/%b exp=0/0", t_rdata, t_ill); end
        checks++; if (m_mscratch !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rw_csr_value got=%h exp=deadbeef", m_mscratch); end
    endtask

    task automatic test_set_clear();
        run_txn(3'b010, 12'h300, 5'd3, 32'h0000_0008, t_we_cnt, t_we_cycle, t_wdata, t_waddr, t_rsp_cycle, t_rdata, t_ill, t_ok);
        checks++; if (t_we_cnt !== 1 || t_wdata !== 32'h0000_1808) begin failures++; $display("FAIL rs_wdata got=%0d/%h exp=1/00001808", t_we_cnt, t_wdata); end
        checks++; if (t_rdata !== 32'h0000_1800 || t_ill !== 1'b0) begin failures++; $display("FAIL rs_rdata got=%h/%b exp=00001800/0", t_rdata, t_ill); end
        run_txn(3'b111, 12'h300, 5'd8, 32'hFFFF_FFFF, t_we_cnt, t_we_cycle, t_wdata, t_waddr, t_rsp_cycle, t_rdata, t_ill, t_ok);
        checks++; if (t_we_cnt !== 1 || t_wdata !== 32'h0000_1800) begin failures++; $display("FAIL rci_wdata got=%0d/%h exp=1/00001800", t_we_cnt, t_wdata); end
        checks++; if (t_rdata !== 32'h0000_1808) begin failures++; $display("FAIL rci_rdata got=%h exp=00001808", t_rdata); end
        run_txn(3'b101, 12'h340, 5'd31, 32'h0000_AAAA, t_we_cnt, t_we_cycle, t_wdata, t_waddr, t_rsp_cycle, t_rdata, t_ill, t_ok);
        checks++; if (t_wdata !== 32'h0000_001F || t_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rwi got=%h/%h exp=0000001f/deadbeef", t_wdata, t_rdata); end
        run_txn(3'b011, 12'h340, 5'd7, 32'h0000_0003, t_we_cnt, t_we_cycle, t_wdata, t_waddr, t_rsp_cycle, t_rdata, t_ill, t_ok);
        checks++; if (t_wdata !== 32'h0000_001C || t_rdata !== 32'h0000_001F) begin failures++; $display("FAIL rc got=%h/%h exp=0000001c/0000001f", t_wdata, t_rdata); end
    endtask

    task automatic test_no_write();
        run_txn(3'b010, 12'h344, 5'd0, 32'hFFFF_FFFF, t_we_cnt, t_we_cycle, t_wdata, t_waddr, t_rsp_cycle, t_rdata, t_ill, t_ok);
        checks++; if (t_we_cnt !== 0) begin failures++; $display("FAIL rs_x0_we got=%0d exp=0", t_we_cnt); end
        checks++; if (t_rdata !== 32'h0000_0080 || t_ill !== 1'b0) begin failures++; $display("FAIL rs_x0_rdata got=%h/%b exp=00000080/0", t_rdata, t_ill); end
        run_txn(3'b111, 12'h344, 5'd0, 32'hFFFF_FFFF, t_we_cnt, t_we_cycle, t_wdata, t_waddr, t_rsp_cycle, t_rdata, t_ill, t_ok);
        checks++; if (t_we_cnt !== 0 || t_rdata !== 32'h0000_0080) begin failures++; $display("FAIL rci_0 got=%0d/%h exp=0/00000080", t_we_cnt, t_rdata); end
        run_txn(3'b010, 12'hF11, 5'd0, 32'h0, t_we_cnt, t_we_cycle, t_wdata, t_waddr, t_rsp_cycle, t_rdata, t_ill, t_ok);
        checks++; if (t_ill !== 1'b0 || t_rdata !== 32'h0000_0ABC) begin failures++; $display("FAIL ro_read got=%b/%h exp=0/00000abc", t_ill, t_rdata); end
    endtask

    task automatic test_illegal();
        run_txn(3'b001, 12'hF11, 5'd5, 32'h1234_5678, t_we_cnt, t_we_cycle, t_wdata, t_waddr, t_rsp_cycle, t_rdata, t_ill, t_ok);
        checks++; if (t_we_cnt !== 0 || t_ill !== 1'b1 || t_rdata !== 32'h0) begin failures++; $display("FAIL ro_write got=%0d/%b/%h exp=0/1/0", t_we_cnt, t_ill, t_rdata); end
        run_txn(3'b001, 12'h7C0, 5'd5, 32'h1234_5678, t_we_cnt, t_we_cycle, t_wdata, t_waddr, t_rsp_cycle, t_rdata, t_ill, t_ok);
        checks++; if (t_we_cnt !== 0 || t_ill !== 1'b1 || t_rdata !== 32'h0) begin failures++; $display("FAIL unimpl got=%0d/%b/%h exp=0/1/0", t_we_cnt, t_ill, t_rdata); end
        run_txn(3'b000, 12'h340, 5'd5, 32'h1234_5678, t_we_cnt, t_we_cycle, t_wdata, t_waddr, t_rsp_cycle, t_rdata, t_ill, t_ok);
        checks++; if (t_we_cnt !== 0 || t_ill !== 1'b1 || t_rdata !== 32'h0) begin failures++; $display("FAIL funct3_0 got=%0d/%b/%h exp=0/1/0", t_we_cnt, t_ill, t_rdata); end
        checks++; if (m_mscratch !== 32'h0000_001C) begin failures++; $display("FAIL illegal_no_write got=%h exp=0000001c", m_mscratch); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] held;
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_funct3 = 3'b010; req_addr = 12'h344; req_rs1_field = 5'd0; req_rs1_data = 32'h0;
        rsp_ready = 1'b0;
        @(posedge clk);
        n = 0;
        do begin @(negedge clk); n++; end while (!rsp_valid && n < 20);
        checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL hold_rsp_timeout got=%b exp=1", rsp_valid); end
        held = rsp_rdata;
        checks++; if (held !== 32'h0000_0080) begin failures++; $display("FAIL hold_rdata got=%h exp=00000080", held); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== held) begin failures++; $display("FAIL hold_stable cyc=%0d got=%b/%h exp=1/%h", i, rsp_valid, rsp_rdata, held); end
            checks++; if (req_ready !== 1'b0 || csr_we !== 1'b0) begin failures++; $display("FAIL hold_busy cyc=%0d got=%b/%b exp=0/0", i, req_ready, csr_we); end
            @(negedge clk);
        end
        $display("txn hold read addr=344 rdata=%h held 5 cycles", held);
        rsp_ready = 1'b1;
        req_funct3 = 3'b001; req_addr = 12'h340; req_rs1_field = 5'd9; req_rs1_data = 32'h0000_0055;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL hold_release got=%b/%b exp=0/1", rsp_valid, req_ready); end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        checks++; if (req_ready !== 1'b0 || mux_addr !== 12'h340) begin failures++; $display("FAIL next_accept got=%b/%h exp=0/340", req_ready, mux_addr); end
        n = 0;
        while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0000_001C) begin failures++; $display("FAIL next_rsp got=%b/%h exp=1/0000001c", rsp_valid, rsp_rdata); end
        $display("txn rw addr=340 wdata=00000055 rdata=%h", rsp_rdata);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++; if (m_mscratch !== 32'h0000_0055) begin failures++; $display("FAIL next_write got=%h exp=00000055", m_mscratch); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req_valid = 1'b1; req_funct3 = 3'b001; req_addr = 12'h340; req_rs1_field = 5'd4; req_rs1_data = 32'h1234_5678;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        checks++; if (csr_we !== 1'b1) begin failures++; $display("FAIL mid_in_write got=%b exp=1", csr_we); end
        rst_n = 1'b0;
        #1;
        checks++; if (csr_we !== 1'b0 || rsp_valid !== 1'b0) begin failures++; $display("FAIL mid_async got=%b/%b exp=0/0", csr_we, rsp_valid); end
        checks++; if (mux_addr !== 12'h0 || csr_waddr !== 12'h0 || csr_wdata !== 32'h0) begin failures++; $display("FAIL mid_outputs got=%h/%h/%h exp=0/0/0", mux_addr, csr_waddr, csr_wdata); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (m_mscratch !== 32'h0000_0055) begin failures++; $display("FAIL mid_no_write got=%h exp=00000055", m_mscratch); end
        checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || csr_we !== 1'b0) begin failures++; $display("FAIL mid_after got=%b/%b/%b exp=1/0/0", req_ready, rsp_valid, csr_we); end
        $display("txn reset during write of rw addr=340, mscratch=%h", m_mscratch);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_funct3 = '0; req_addr = '0;
        req_rs1_field = '0; req_rs1_data = '0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_csrrw();
        test_set_clear();
        test_no_write();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
